// File: rtl/serial_tx_arbiter.sv
// Two-requester round-robin arbiter driving a framed serial line:
// start bit, DATA_W data bits MSB first, stop bit, then GAP idle bit-times.
module serial_tx_arbiter #(
    parameter int DATA_W = 8,
    parameter int GAP    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              ser_cs_n,
    output logic              ser_out,
    output logic              busy,
    output logic              grant_id,
    output logic              frame_done
);
    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [3:0]       GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  bit_cnt_r, bit_cnt_s;
    logic [3:0]        gap_cnt_r, gap_cnt_s;
    logic [DATA_W-1:0] shift_r, shift_s;
    logic              last_grant_r, last_grant_s;
    logic              grant_id_r, grant_id_s;
    logic              cs_n_r, cs_n_s;
    logic              sout_r, sout_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              win_s;
    logic              accept_s;

    // Round-robin winner: on a tie the requester not granted last wins
    always_comb begin
        if (req0_valid && req1_valid) begin
            win_s = ~last_grant_r;
        end else begin
            win_s = req1_valid;
        end
    end

    // rst_n gates the readys so nothing is accepted while reset is held
    assign accept_s   = rst_n && ena && (state_r == ST_IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept_s && !win_s;
    assign req1_ready = accept_s && win_s;

    // Next-state, datapath and next pin values
    always_comb begin
        state_s      = state_r;
        bit_cnt_s    = bit_cnt_r;
        gap_cnt_s    = gap_cnt_r;
        shift_s      = shift_r;
        last_grant_s = last_grant_r;
        grant_id_s   = grant_id_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    shift_s      = win_s ? req1_data : req0_data;
                    last_grant_s = win_s;
                    grant_id_s   = win_s;
                    state_s      = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                bit_cnt_s = {CNT_W{1'b0}};
                state_s   = ST_DATA;
            end
            ST_DATA: begin
                shift_s = shift_r << 1'b1;
                if (bit_cnt_r == BIT_LAST) begin
                    state_s = ST_STOP;
                end else begin
                    bit_cnt_s = bit_cnt_r + CNT_W'(1);
                end
            end
            ST_STOP: begin
                gap_cnt_s = 4'd0;
                if (GAP > 0) begin
                    state_s = ST_GAP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_s = ST_IDLE;
                end else begin
                    gap_cnt_s = gap_cnt_r + 4'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Pins are computed for the state being entered so they come straight from flops
        cs_n_s = !((state_s == ST_START) || (state_s == ST_DATA) || (state_s == ST_STOP));
        busy_s = (state_s != ST_IDLE);
        done_s = (state_s == ST_STOP);
        if (state_s == ST_DATA) begin
            sout_s = shift_s[DATA_W-1];
        end else if (state_s == ST_START) begin
            sout_s = 1'b0;
        end else begin
            sout_s = 1'b1;
        end
    end

    // State, datapath and registered pin drivers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= {CNT_W{1'b0}};
            gap_cnt_r    <= 4'd0;
            shift_r      <= {DATA_W{1'b0}};
            last_grant_r <= 1'b1;
            grant_id_r   <= 1'b0;
            cs_n_r       <= 1'b1;
            sout_r       <= 1'b1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            bit_cnt_r    <= bit_cnt_s;
            gap_cnt_r    <= gap_cnt_s;
            shift_r      <= shift_s;
            last_grant_r <= last_grant_s;
            grant_id_r   <= grant_id_s;
            cs_n_r       <= cs_n_s;
            sout_r       <= sout_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
        end
    end

    assign ser_cs_n   = cs_n_r;
    assign ser_out    = sout_r;
    assign busy       = busy_r;
    assign grant_id   = grant_id_r;
    assign frame_done = done_r;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Self-checking bench for serial_tx_arbiter: a frame monitor pops expected
// {grant_id, payload} entries that the stimulus tasks push at acceptance.
module tb_serial_tx_arbiter;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic          req0_valid;
    logic          req1_valid;
    logic [DW-1:0] req0_data;
    logic [DW-1:0] req1_data;
    logic          req0_ready;
    logic          req1_ready;
    logic          ser_cs_n;
    logic          ser_out;
    logic          busy;
    logic          grant_id;
    logic          frame_done;

    logic          g_req1_valid;
    logic [DW-1:0] g_req1_data;
    logic          g_req0_ready;
    logic          g_req1_ready;
    logic          g_ser_cs_n;
    logic          g_ser_out;
    logic          g_busy;
    logic          g_grant_id;
    logic          g_frame_done;

    int            checks = 0;
    int            errors = 0;
    logic [DW:0]   sb_q[$];

    always #5 clk = ~clk;

    serial_tx_arbiter #(.DATA_W(DW), .GAP(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .ser_cs_n(ser_cs_n), .ser_out(ser_out), .busy(busy),
        .grant_id(grant_id), .frame_done(frame_done)
    );

    serial_tx_arbiter #(.DATA_W(DW), .GAP(0)) u_dut_g0 (
        .clk(clk), .rst_n(rst_n), .ena(1'b1),
        .req0_valid(1'b0), .req0_data({DW{1'b0}}), .req0_ready(g_req0_ready),
        .req1_valid(g_req1_valid), .req1_data(g_req1_data), .req1_ready(g_req1_ready),
        .ser_cs_n(g_ser_cs_n), .ser_out(g_ser_out), .busy(g_busy),
        .grant_id(g_grant_id), .frame_done(g_frame_done)
    );

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reassembles frames of the GAP=1 instance and scores them against sb_q
    task automatic monitor();
        int          n = 0;
        logic [DW-1:0] bits = '0;
        logic [DW:0] exp_v;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                n = 0;
            end else if (ser_cs_n) begin
                if (n != 0) begin
                    checks++;
                    if (n != DW + 2) begin
                        errors++;
                        $display("FAIL frame_length: got %0d bit-times, want %0d", n, DW + 2);
                    end
                end
                n = 0;
            end else begin
                checks++;
                if (frame_done !== (n == DW + 1)) begin
                    errors++;
                    $display("FAIL frame_done_pos: at bit %0d got %b want %b", n, frame_done, (n == DW + 1));
                end
                if (n == 0) begin
                    checks++;
                    if (ser_out !== 1'b0) begin
                        errors++;
                        $display("FAIL start_bit: got %b want 0", ser_out);
                    end
                end else if (n <= DW) begin
                    bits = {bits[DW-2:0], ser_out};
                end else if (n == DW + 1) begin
                    checks++;
                    if (ser_out !== 1'b1) begin
                        errors++;
                        $display("FAIL stop_bit: got %b want 1", ser_out);
                    end
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_frame: got id %b data %h, want no frame", grant_id, bits);
                    end else begin
                        exp_v = sb_q.pop_front();
                        checks++;
                        if ({grant_id, bits} !== exp_v) begin
                            errors++;
                            $display("FAIL frame_payload: got id %b data %h, want id %b data %h",
                                     grant_id, bits, exp_v[DW], exp_v[DW-1:0]);
                        end
                    end
                end
                n++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 8'h11; req1_data = 8'h22;
        g_req1_valid = 1'b0; g_req1_data = 8'h00;
        repeat (3) tick();
        checks++;
        if ({ser_cs_n, ser_out, busy, frame_done, grant_id} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 11000", {ser_cs_n, ser_out, busy, frame_done, grant_id});
        end
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_single();
        int low = 0;
        req0_valid = 1'b1; req0_data = 8'hA9; rst_n = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL single_accept: got %b want 10", {req0_ready, req1_ready});
        end
        sb_q.push_back({1'b0, 8'hA9});
        tick();
        checks++;
        if (req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_ready_busy: got %b want 0", req0_ready);
        end
        req0_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (!ser_cs_n) low++;
            tick();
        end
        checks++;
        if (low != 10) begin
            errors++;
            $display("FAIL single_cs_low: got %0d cycles want 10", low);
        end
        checks++;
        if ({busy, grant_id} !== 2'b00) begin
            errors++;
            $display("FAIL single_idle: got busy/grant %b want 00", {busy, grant_id});
        end
    endtask

    task automatic test_round_robin();
        logic e0, e1;
        rst_n = 1'b0;
        tick();
        req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 8'h3C; req1_data = 8'hC3;
        rst_n = 1'b1;
        for (int c = 0; c < 48; c++) begin
            if (c > 0) tick();
            if (c == 3) req0_data = 8'h55;
            #1;
            e0 = (c % 12 == 0) && ((c / 12) % 2 == 0);
            e1 = (c % 12 == 0) && ((c / 12) % 2 == 1);
            checks++;
            if ({req0_ready, req1_ready} !== {e0, e1}) begin
                errors++;
                $display("FAIL rr_ready c=%0d: got %b want %b", c, {req0_ready, req1_ready}, {e0, e1});
            end
            if (e0) sb_q.push_back({1'b0, req0_data});
            if (e1) sb_q.push_back({1'b1, req1_data});
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_ena();
        int low = 0;
        ena = 1'b0; req1_valid = 1'b1; req1_data = 8'hE7;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({req0_ready, req1_ready, ser_cs_n, busy} !== 4'b0010) begin
                errors++;
                $display("FAIL ena_blocked i=%0d: got %b want 0010", i, {req0_ready, req1_ready, ser_cs_n, busy});
            end
        end
        tick();
        ena = 1'b1;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL ena_accept: got %b want 1", req1_ready);
        end
        sb_q.push_back({1'b1, 8'hE7});
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (c == 5) ena = 1'b0;
            #1;
            checks++;
            if (req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL ena_hold c=%0d: got %b want 0", c, req1_ready);
            end
            if (!ser_cs_n) low++;
        end
        checks++;
        if (low != 10) begin
            errors++;
            $display("FAIL ena_frame_len: got %0d cycles want 10", low);
        end
        ena = 1'b1; req1_data = 8'h18;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL ena_reaccept: got %b want 1", req1_ready);
        end
        sb_q.push_back({1'b1, 8'h18});
        tick();
        req1_valid = 1'b0;
        repeat (14) tick();
    endtask

    task automatic test_reset_mid();
        int low = 0;
        req0_valid = 1'b1; req0_data = 8'h5A;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmid_accept: got %b want 1", req0_ready);
        end
        for (int c = 1; c <= 5; c++) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ser_cs_n, ser_out, busy, frame_done, req0_ready} !== 5'b11000) begin
            errors++;
            $display("FAIL rmid_async: got %b want 11000", {ser_cs_n, ser_out, busy, frame_done, req0_ready});
        end
        tick();
        rst_n = 1'b1; req0_data = 8'h96;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmid_reaccept: got %b want 1", req0_ready);
        end
        sb_q.push_back({1'b0, 8'h96});
        tick();
        req0_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (!ser_cs_n) low++;
            tick();
        end
        checks++;
        if (low != 10) begin
            errors++;
            $display("FAIL rmid_frame_len: got %0d cycles want 10", low);
        end
    endtask

    task automatic test_back_to_back_gap0();
        logic [DW-1:0] gq[$];
        logic [DW-1:0] gbits = '0;
        logic [DW-1:0] gexp;
        g_req1_valid = 1'b1; g_req1_data = 8'hB4;
        for (int c = 0; c < 33; c++) begin
            if (c > 0) tick();
            if (c == 4) g_req1_data = 8'h6D;
            #1;
            checks++;
            if ({g_req0_ready, g_req1_ready, g_ser_cs_n} !== {1'b0, (c % 11 == 0), (c % 11 == 0)}) begin
                errors++;
                $display("FAIL g0_ready_cs c=%0d: got %b want %b", c,
                         {g_req0_ready, g_req1_ready, g_ser_cs_n}, {1'b0, (c % 11 == 0), (c % 11 == 0)});
            end
            if (c % 11 == 0) gq.push_back(g_req1_data);
            if ((c % 11 >= 2) && (c % 11 <= 9)) gbits = {gbits[DW-2:0], g_ser_out};
            if (c % 11 == 9) begin
                gexp = gq.pop_front();
                checks++;
                if (gbits !== gexp) begin
                    errors++;
                    $display("FAIL g0_payload c=%0d: got %h want %h", c, gbits, gexp);
                end
            end
            if (c % 11 == 10) begin
                checks++;
                if ({g_frame_done, g_ser_out, g_grant_id} !== 3'b111) begin
                    errors++;
                    $display("FAIL g0_stop c=%0d: got %b want 111", c, {g_frame_done, g_ser_out, g_grant_id});
                end
            end
        end
        g_req1_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if ({g_busy, g_ser_cs_n} !== 2'b01) begin
            errors++;
            $display("FAIL g0_idle: got %b want 01", {g_busy, g_ser_cs_n});
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_single();
        test_round_robin();
        test_ena();
        test_reset_mid();
        test_back_to_back_gap0();
        repeat (2) tick();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending frames want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
